// File: rtl/red_pitaya_adc_spi_tx.sv
// 3-wire SPI shift engine for the ADC configuration port: sends address then data MSB-first,
// and optionally turns the data line around to capture read data.
module red_pitaya_adc_spi_tx #(
  parameter int unsigned CLK_DIV = 10,
  parameter int unsigned H_LNG   = 8,
  parameter int unsigned L_LNG   = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [15:0] adr_i,
  input  logic [15:0] dat_i,
  input  logic        rw_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] rd_dat_o,
  output logic        spi_cs_o,
  output logic        spi_clk_o,
  output logic        spi_mosi_o,
  output logic        spi_mosi_t,
  input  logic        spi_miso_i
);

  localparam int unsigned HP = CLK_DIV / 2;
  localparam int unsigned N  = H_LNG + L_LNG;
  localparam int unsigned SW = 32;
  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GUARD = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [BW-1:0]   bit_cnt, bit_nxt, bit_inc;
  logic [SW-1:0]   sreg, sreg_nxt;
  logic            rw_q, rw_nxt;
  logic            busy_nxt, done_nxt, cs_nxt, sck_nxt, mosi_nxt, mosi_t_nxt;
  logic [15:0]     rd_nxt;
  logic            cnt_zero;
  logic            unused_inputs;

  // Address/data bits above H_LNG/L_LNG are intentionally ignored.
  assign unused_inputs = ^{adr_i, dat_i};
  assign cnt_zero      = (cnt == '0);
  assign bit_inc       = bit_cnt + BW'(1);

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      sreg       <= '0;
      rw_q       <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      rd_dat_o   <= '0;
      spi_cs_o   <= 1'b1;
      spi_clk_o  <= 1'b1;
      spi_mosi_o <= 1'b0;
      spi_mosi_t <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_nxt;
      sreg       <= sreg_nxt;
      rw_q       <= rw_nxt;
      busy_o     <= busy_nxt;
      done_o     <= done_nxt;
      rd_dat_o   <= rd_nxt;
      spi_cs_o   <= cs_nxt;
      spi_clk_o  <= sck_nxt;
      spi_mosi_o <= mosi_nxt;
      spi_mosi_t <= mosi_t_nxt;
    end
  end

  // Next-state and next-output logic; every phase is timed by the half-period counter.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_cnt;
    sreg_nxt   = sreg;
    rw_nxt     = rw_q;
    busy_nxt   = busy_o;
    done_nxt   = 1'b0;
    rd_nxt     = rd_dat_o;
    cs_nxt     = spi_cs_o;
    sck_nxt    = spi_clk_o;
    mosi_nxt   = spi_mosi_o;
    mosi_t_nxt = spi_mosi_t;

    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt  = SETUP;
          cnt_nxt    = CW'(HP - 1);
          bit_nxt    = '0;
          sreg_nxt   = SW'({adr_i[H_LNG-1:0], dat_i[L_LNG-1:0]}) << (SW - N);
          rw_nxt     = rw_i;
          busy_nxt   = 1'b1;
          cs_nxt     = 1'b0;
          sck_nxt    = 1'b1;
          mosi_nxt   = adr_i[H_LNG-1];
          mosi_t_nxt = 1'b0;
        end
      end

      SETUP: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          state_nxt = SHIFT;
          sck_nxt   = 1'b0;
          cnt_nxt   = CW'(HP - 1);
        end
      end

      SHIFT: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - CW'(1);
        end else if (!spi_clk_o) begin
          // Rising edge: capture MISO during the read data phase.
          sck_nxt = 1'b1;
          cnt_nxt = CW'(HP - 1);
          if (rw_q && (bit_cnt >= BW'(H_LNG))) begin
            if (bit_cnt == BW'(H_LNG)) begin
              rd_nxt = {15'd0, spi_miso_i};
            end else begin
              rd_nxt = {rd_dat_o[14:0], spi_miso_i};
            end
          end
        end else if (bit_cnt == BW'(N - 1)) begin
          state_nxt = HOLD;
          cnt_nxt   = CW'(HP - 1);
        end else begin
          // Falling edge: advance to the next bit or turn the line around.
          sck_nxt  = 1'b0;
          cnt_nxt  = CW'(HP - 1);
          bit_nxt  = bit_inc;
          sreg_nxt = sreg << 1;
          if (rw_q && (bit_inc >= BW'(H_LNG))) begin
            mosi_nxt   = 1'b0;
            mosi_t_nxt = 1'b1;
          end else begin
            mosi_nxt = sreg[SW-2];
          end
        end
      end

      HOLD: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          state_nxt  = GUARD;
          cs_nxt     = 1'b1;
          mosi_nxt   = 1'b0;
          mosi_t_nxt = 1'b0;
          cnt_nxt    = CW'(CLK_DIV - 1);
        end
      end

      GUARD: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_red_pitaya_adc_spi_tx.sv
// Bench for red_pitaya_adc_spi_tx: default-parameter instance for directed/random frames,
// plus a CLK_DIV=2, 16+16 bit instance with start held high.
module tb_red_pitaya_adc_spi_tx;

  localparam int unsigned CD = 10, H = 8, L = 8, N = 16, HP = CD / 2;
  localparam int unsigned BUSY_A = HP + N * CD + HP + CD;
  localparam int unsigned CD_B = 2, H_B = 16, L_B = 16, N_B = 32;
  localparam int unsigned BUSY_B = CD_B / 2 + N_B * CD_B + CD_B / 2 + CD_B;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 0, rw_a = 0, miso_a = 0;
  logic [15:0] adr_a = 0, dat_a = 0;
  logic        busy_a, done_a, cs_a, sck_a, mosi_a, mt_a;
  logic [15:0] rd_a;

  logic        start_b = 0, rw_b = 0, miso_b = 0;
  logic [15:0] adr_b = 0, dat_b = 0;
  logic        busy_b, done_b, cs_b, sck_b, mosi_b, mt_b;
  logic [15:0] rd_b;

  red_pitaya_adc_spi_tx #(.CLK_DIV(CD), .H_LNG(H), .L_LNG(L)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_a), .adr_i(adr_a), .dat_i(dat_a), .rw_i(rw_a),
    .busy_o(busy_a), .done_o(done_a), .rd_dat_o(rd_a), .spi_cs_o(cs_a), .spi_clk_o(sck_a),
    .spi_mosi_o(mosi_a), .spi_mosi_t(mt_a), .spi_miso_i(miso_a));

  red_pitaya_adc_spi_tx #(.CLK_DIV(CD_B), .H_LNG(H_B), .L_LNG(L_B)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_b), .adr_i(adr_b), .dat_i(dat_b), .rw_i(rw_b),
    .busy_o(busy_b), .done_o(done_b), .rd_dat_o(rd_b), .spi_cs_o(cs_b), .spi_clk_o(sck_b),
    .spi_mosi_o(mosi_b), .spi_mosi_t(mt_b), .spi_miso_i(miso_b));

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor A: bus-level observation of the default instance plus a simple MISO slave.
  int          busy_cyc = 0, done_cnt = 0, frames = 0, rises = 0, fall_idx = -1, t_idle_err = 0;
  int          gap_cur = 0;
  int          gap_q[$];
  logic [31:0] frame_q[$];
  logic [31:0] mosi_w = 0, t_w = 0;
  logic [7:0]  slave_a = 0;
  logic        prev_sck_a = 1, prev_cs_a = 1, prev_busy_a = 0;

  always @(negedge clk) begin
    if (busy_a) busy_cyc++;
    if (done_a) done_cnt++;
    if (cs_a && mt_a) t_idle_err++;
    if (prev_cs_a && !cs_a) begin
      frames++; fall_idx = -1; mosi_w = 0; t_w = 0; rises = 0;
    end
    if (!cs_a && prev_sck_a && !sck_a) fall_idx++;
    if (!cs_a && !prev_sck_a && sck_a) begin
      rises++;
      mosi_w = {mosi_w[30:0], mosi_a};
      t_w    = {t_w[30:0], mt_a};
    end
    if (!prev_cs_a && cs_a) frame_q.push_back(mosi_w);
    if (!prev_busy_a && busy_a) gap_q.push_back(gap_cur);
    if (busy_a) gap_cur = 0; else gap_cur++;
    if (fall_idx >= int'(H) && fall_idx < int'(N)) miso_a = slave_a[int'(N) - 1 - fall_idx];
    else miso_a = 1'($urandom);
    prev_sck_a = sck_a; prev_cs_a = cs_a; prev_busy_a = busy_a;
  end

  // Monitor B: per-frame busy length, idle gap, rising-edge count and spacing.
  int          cyc_b = 0, bcur_b = 0, gcur_b = 0, rcur_b = 0, last_rise_b = -1, int_err_b = 0;
  bit          seen_b = 0;
  int          busyq_b[$], gapq_b[$], riseq_b[$];
  logic [31:0] mwq_b[$];
  logic [31:0] mw_b = 0;
  logic        prev_sck_b = 1, prev_cs_b = 1, prev_busy_b = 0;

  always @(negedge clk) begin
    if (prev_busy_b && !busy_b) busyq_b.push_back(bcur_b);
    if (!prev_busy_b && busy_b) begin
      if (seen_b) gapq_b.push_back(gcur_b);
      seen_b = 1; gcur_b = 0; bcur_b = 0;
    end
    if (busy_b) bcur_b++; else gcur_b++;
    if (prev_cs_b && !cs_b) begin rcur_b = 0; last_rise_b = -1; mw_b = 0; end
    if (!cs_b && !prev_sck_b && sck_b) begin
      if (last_rise_b >= 0 && (cyc_b - last_rise_b) != int'(CD_B)) int_err_b++;
      last_rise_b = cyc_b;
      rcur_b++;
      mw_b = {mw_b[30:0], mosi_b};
    end
    if (!prev_cs_b && cs_b) begin riseq_b.push_back(rcur_b); mwq_b.push_back(mw_b); end
    cyc_b++;
    prev_sck_b = sck_b; prev_cs_b = cs_b; prev_busy_b = busy_b;
  end

  logic [15:0] rd_model = 0;

  task automatic clr_a();
    busy_cyc = 0; done_cnt = 0; frames = 0; t_idle_err = 0;
    frame_q.delete(); gap_q.delete();
  endtask

  task automatic wait_done_a(input string tag);
    bit got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_a) begin got = 1; break; end
    end
    if (!got) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  // One frame on instance A, checked against the frame the rules predict.
  task automatic do_txn(input logic [15:0] adr, input logic [15:0] dat, input logic rw,
                        input logic [7:0] slave, input bit pulses);
    logic [31:0] exp_mosi, exp_t;
    bit got = 0;
    @(posedge clk); #1;
    clr_a();
    slave_a = slave; adr_a = adr; dat_a = dat; rw_a = rw; start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pulses) begin
        if (i == 19 || i == 99) begin start_a = 1; adr_a = 16'($urandom); rw_a = ~rw; end
        else start_a = 0;
      end
      if (done_a) begin got = 1; break; end
    end
    start_a = 0;
    if (!got) chk("txn_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    exp_mosi = 32'({adr[H-1:0], rw ? 8'h00 : dat[L-1:0]});
    exp_t    = rw ? 32'h0000_00FF : 32'h0;
    if (rw) rd_model = 16'(slave);
    chk("busy_cycles", 32'(busy_cyc), 32'(BUSY_A));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("frames", 32'(frames), 32'd1);
    chk("rising_edges", 32'(rises), 32'(N));
    chk("mosi_word", mosi_w, exp_mosi);
    chk("tristate_word", t_w, exp_t);
    chk("tristate_outside_cs", 32'(t_idle_err), 32'd0);
    chk("rd_dat", 32'(rd_a), 32'(rd_model));
    chk("idle_outputs", 32'({busy_a, done_a, cs_a, sck_a, mosi_a, mt_a}), 32'b001100);
  endtask

  initial begin
    logic [15:0] b2b_adr[4] = '{16'h01, 16'h02, 16'h03, 16'h04};
    logic [15:0] b2b_dat[4] = '{16'h00, 16'h01, 16'h02, 16'h00};

    // Reset values while reset is held.
    #12;
    chk("reset_ctrl_a", 32'({busy_a, done_a, cs_a, sck_a, mosi_a, mt_a}), 32'b001100);
    chk("reset_rd_a", 32'(rd_a), 32'd0);
    chk("reset_ctrl_b", 32'({busy_b, done_b, cs_b, sck_b, mosi_b, mt_b}), 32'b001100);
    repeat (3) @(posedge clk);
    #1 rstn = 1;

    do_txn(16'h0003, 16'h0002, 1'b0, 8'h00, 0);
    do_txn(16'h0083, 16'h0000, 1'b1, 8'hA5, 0);
    for (int i = 0; i < 4; i++)
      do_txn(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 0);
    // Starts during an active frame must be ignored.
    do_txn(16'h0044, 16'h0055, 1'b0, 8'h00, 1);
    do_txn(16'h00C1, 16'h0000, 1'b1, 8'h3C, 1);

    // Reset at cycle 70 of a frame.
    @(posedge clk); #1;
    clr_a();
    adr_a = 16'h00F0; dat_a = 16'h000F; rw_a = 0; start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    repeat (69) @(posedge clk);
    #1 rstn = 0;
    #1;
    chk("midrst_cs_clk_busy", 32'({cs_a, sck_a, busy_a}), 32'b110);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    rd_model = 0;
    chk("midrst_rd_cleared", 32'(rd_a), 32'd0);
    do_txn(16'h005A, 16'h00A5, 1'b0, 8'h00, 0);

    // Four back-to-back writes, each started in the previous done cycle.
    @(posedge clk); #1;
    clr_a();
    adr_a = b2b_adr[0]; dat_a = b2b_dat[0]; rw_a = 0; start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    for (int f = 1; f < 4; f++) begin
      wait_done_a("b2b");
      adr_a = b2b_adr[f]; dat_a = b2b_dat[f]; start_a = 1;
      @(negedge clk);
      start_a = 0;
    end
    wait_done_a("b2b_last");
    @(posedge clk); #1;
    chk("b2b_frames", 32'(frame_q.size()), 32'd4);
    chk("b2b_done", 32'(done_cnt), 32'd4);
    chk("b2b_busy", 32'(busy_cyc), 32'(4 * BUSY_A));
    for (int f = 0; f < 4; f++) begin
      if (f < frame_q.size())
        chk($sformatf("b2b_word%0d", f), frame_q[f], 32'({b2b_adr[f][7:0], b2b_dat[f][7:0]}));
      if (f > 0 && f < gap_q.size())
        chk($sformatf("b2b_idle%0d", f), 32'(gap_q[f]), 32'd1);
    end

    // Instance B: fastest clock, widest frame, start held high.
    @(posedge clk); #1;
    adr_b = 16'($urandom); dat_b = 16'($urandom); start_b = 1;
    for (int i = 0; i < 1000 && busyq_b.size() < 3; i++) @(posedge clk);
    #1 start_b = 0;
    for (int i = 0; i < 200 && busy_b; i++) @(posedge clk);
    #1;
    chk("b_frames_seen", 32'(busyq_b.size() >= 3), 32'd1);
    for (int f = 0; f < 3; f++) begin
      if (f < busyq_b.size()) chk($sformatf("b_busy%0d", f), 32'(busyq_b[f]), 32'(BUSY_B));
      if (f < riseq_b.size()) chk($sformatf("b_rises%0d", f), 32'(riseq_b[f]), 32'(N_B));
      if (f < 2 && f < gapq_b.size()) chk($sformatf("b_idle%0d", f), 32'(gapq_b[f]), 32'd1);
    end
    chk("b_sclk_period", 32'(int_err_b), 32'd0);
    if (mwq_b.size() > 0) chk("b_word0", mwq_b[0], {adr_b, dat_b});
    else chk("b_word0_missing", 32'd1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
